ff_frame_player: RTL and testbench

Receive-path counterpart of the MII transmit block: takes complete frame payload buffers handed over from the MII receive side and plays them out serially to the modulator, one bit per `ff_clk`. Frame hand-over uses a toggle crossing into the `ff_clk` domain. Each buffer carries a 24-bit frame ID plus 625 payload bits. The block reports `empty` so the transmit side can request new frames from the PC.

---
 rtl/ff_frame_pkg.sv | 19 +
 rtl/ff_frame_player_toggle_sync.sv | 27 ++
 rtl/ff_frame_player.sv | 109 ++++++++++
 tb/tb_ff_frame_player.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_frame_pkg.sv
// Shared constants and state encoding for the frame player and the MII transmit block.
package ff_frame_pkg;

  localparam int FF_PAYLOAD_BITS = 625;
  localparam int FF_ID_BITS      = 24;
  localparam int FF_BUF_BITS     = FF_PAYLOAD_BITS + FF_ID_BITS;

`ifdef FRAMEID_CHECK_EN
  localparam bit FF_FRAMEID_CHECK = 1'b1;
`else
  localparam bit FF_FRAMEID_CHECK = 1'b0;
`endif

  typedef enum logic {
    FP_IDLE = 1'b0,
    FP_PLAY = 1'b1
  } fp_state_t;

endpackage

// File: rtl/ff_frame_player_toggle_sync.sv
// Toggle-based event crossing: 2-flop synchronizer plus history flop, one-cycle nf per toggle edge.
module toggle_sync (
  input  logic clk,
  input  logic reset,
  input  logic toggle,
  output logic nf
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= toggle;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign nf = s2 ^ s3;

endmodule

// File: rtl/ff_frame_player.sv
// Plays frame payload buffers out serially, one bit per ff_clk, reporting empty/overrun.
// Optional macro FRAMEID_CHECK_EN builds the frame-ID continuity checker driving seq_err.
module ff_frame_player
  import ff_frame_pkg::*;
#(
  parameter int PAYLOAD_BITS = FF_PAYLOAD_BITS,
  parameter int ID_BITS      = FF_ID_BITS
) (
  input  logic                            ff_clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [PAYLOAD_BITS+ID_BITS-1:0] frame_buf,
  input  logic                            frame_toggle,
  output logic                            ff_en,
  output logic                            ff_data,
  output logic [ID_BITS-1:0]              frameid,
  output logic                            empty,
  output logic                            overrun,
  output logic                            seq_err
);

  localparam int             BUF_BITS = PAYLOAD_BITS + ID_BITS;
  localparam logic [9:0]     CNT_LAST = 10'(PAYLOAD_BITS - 1);

  logic                    nf;
  fp_state_t               state;
  logic [BUF_BITS-1:0]     shadow;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [9:0]              bit_cnt;
  logic                    pending;
  logic                    last_bit;
  logic                    load;

  toggle_sync u_sync (
    .clk    (ff_clk),
    .reset  (reset),
    .toggle (frame_toggle),
    .nf     (nf)
  );

  // A frame starts from IDLE or chains directly off the last bit of the current one.
  always_comb begin
    last_bit = (bit_cnt == CNT_LAST);
    load     = start && pending && ((state == FP_IDLE) || last_bit);
  end

  always_ff @(posedge ff_clk) begin
    if (reset) begin
      state   <= FP_IDLE;
      shadow  <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      pending <= 1'b0;
      frameid <= '0;
      ff_en   <= 1'b0;
      ff_data <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= nf && pending && !load;

      // Capture wins over consumption, so a frame arriving on a reload edge stays pending.
      if (nf) begin
        shadow  <= frame_buf;
        pending <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end

      // ff_data mirrors shreg[0] after the edge, so it is preloaded from the next LSB.
      if (load) begin
        state   <= FP_PLAY;
        shreg   <= shadow[BUF_BITS-1:ID_BITS];
        frameid <= shadow[ID_BITS-1:0];
        bit_cnt <= '0;
        ff_en   <= 1'b1;
        ff_data <= shadow[ID_BITS];
      end else if ((state == FP_PLAY) && start && !last_bit) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 10'd1;
        ff_data <= shreg[1];
      end else begin
        state   <= FP_IDLE;
        bit_cnt <= '0;
        ff_en   <= 1'b0;
        ff_data <= 1'b0;
      end
    end
  end

  assign empty = ~pending;

`ifdef FRAMEID_CHECK_EN
  logic have_prev;

  always_ff @(posedge ff_clk) begin
    if (reset) begin
      have_prev <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      seq_err   <= load && have_prev &&
                   (shadow[ID_BITS-1:0] != ID_BITS'(frameid + 1'b1));
      have_prev <= have_prev | load;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_ff_frame_player.sv
// Scenario bench for ff_frame_player: random payloads/IDs checked against expected frame order and timing.
module tb_ff_frame_player;
  import ff_frame_pkg::*;

  localparam int PB = FF_PAYLOAD_BITS;
  localparam int IB = FF_ID_BITS;
`ifdef FRAMEID_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic          ff_clk;
  logic          reset;
  logic          start;
  logic [PB+IB-1:0] frame_buf;
  logic          frame_toggle;
  logic          ff_en;
  logic          ff_data;
  logic [IB-1:0] frameid;
  logic          empty;
  logic          overrun;
  logic          seq_err;

  ff_frame_player #(
    .PAYLOAD_BITS (PB),
    .ID_BITS      (IB)
  ) dut (
    .ff_clk       (ff_clk),
    .reset        (reset),
    .start        (start),
    .frame_buf    (frame_buf),
    .frame_toggle (frame_toggle),
    .ff_en        (ff_en),
    .ff_data      (ff_data),
    .frameid      (frameid),
    .empty        (empty),
    .overrun      (overrun),
    .seq_err      (seq_err)
  );

  initial ff_clk = 1'b0;
  always #5 ff_clk = ~ff_clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            at;
    logic [IB-1:0] id;
    logic [PB-1:0] p;
  } sched_t;
  sched_t sq[$];

  logic [PB-1:0] cap_data;
  logic [IB-1:0] cap_id;
  int cap_en, cap_id_chg, cap_empty_hi, cap_se_cnt, ov_total;
  logic cap_se_first;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ff_clk);
      #1;
    end
  endtask

  function automatic logic [PB-1:0] rand_payload();
    logic [PB-1:0] v;
    for (int i = 0; i < PB; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [PB-1:0] alt_payload();
    logic [PB-1:0] v;
    for (int i = 0; i < PB; i++) v[i] = ((i % 2) == 0);
    return v;
  endfunction

  task automatic send(input logic [IB-1:0] id, input logic [PB-1:0] p);
    frame_buf    = {p, id};
    frame_toggle = ~frame_toggle;
  endtask

  task automatic sched(input int at, input logic [IB-1:0] id, input logic [PB-1:0] p);
    sched_t e;
    e.at = at;
    e.id = id;
    e.p  = p;
    sq.push_back(e);
  endtask

  // Observe n consecutive cycles, issuing any scheduled hand-overs at their cycle index.
  task automatic capture(input int n);
    sched_t s;
    cap_data     = '0;
    cap_en       = 0;
    cap_id       = frameid;
    cap_id_chg   = 0;
    cap_empty_hi = 0;
    cap_se_cnt   = 0;
    cap_se_first = seq_err;
    for (int i = 0; i < n; i++) begin
      cap_data[i]   = ff_data;
      cap_en       += int'(ff_en);
      if (frameid !== cap_id) cap_id_chg++;
      cap_empty_hi += int'(empty);
      cap_se_cnt   += int'(seq_err);
      ov_total     += int'(overrun);
      if (sq.size() > 0 && sq[0].at == i) begin
        s = sq.pop_front();
        send(s.id, s.p);
      end
      step(1);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    start        = 1'b0;
    frame_toggle = 1'b0;
    frame_buf    = '0;
    sq.delete();
    step(3);
    reset    = 1'b0;
    ov_total = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; frame_toggle = 1'b0; frame_buf = '0;
    step(2);
    checks++; if (ff_en !== 1'b0)   begin failures++; $display("FAIL reset_ff_en: got %b expected 0", ff_en); end
    checks++; if (ff_data !== 1'b0) begin failures++; $display("FAIL reset_ff_data: got %b expected 0", ff_data); end
    checks++; if (frameid !== '0)   begin failures++; $display("FAIL reset_frameid: got %h expected 0", frameid); end
    checks++; if (empty !== 1'b1)   begin failures++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [PB-1:0] p;
    p = alt_payload();
    do_reset();
    start = 1'b1;
    send(24'h000001, p);
    step(3);
    checks++; if (ff_en !== 1'b0) begin failures++; $display("FAIL single_early_en: got %b expected 0", ff_en); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_pending: empty got %b expected 0", empty); end
    step(1);
    capture(PB);
    checks++; if (cap_en !== PB) begin failures++; $display("FAIL single_en_len: got %0d expected %0d", cap_en, PB); end
    checks++; if (cap_data !== p) begin failures++; $display("FAIL single_data: got %h expected %h", cap_data, p); end
    checks++; if (cap_id !== 24'h000001 || cap_id_chg !== 0) begin failures++; $display("FAIL single_frameid: got %h (changes %0d) expected 000001", cap_id, cap_id_chg); end
    checks++; if (cap_empty_hi !== PB) begin failures++; $display("FAIL single_empty: high cycles got %0d expected %0d", cap_empty_hi, PB); end
    checks++; if (ff_en !== 1'b0) begin failures++; $display("FAIL single_end_en: got %b expected 0", ff_en); end
    checks++; if (ov_total !== 0) begin failures++; $display("FAIL single_overrun: got %0d expected 0", ov_total); end
  endtask

  task automatic test_back_to_back();
    logic [PB-1:0] p1, p2;
    logic [IB-1:0] id1;
    p1 = rand_payload(); p2 = rand_payload(); id1 = IB'($urandom);
    do_reset();
    start = 1'b1;
    send(id1, p1);
    step(4);
    sched(100, id1 + 1'b1, p2);
    capture(PB);
    checks++; if (cap_en !== PB || cap_data !== p1) begin failures++; $display("FAIL b2b_frame1: en %0d data %h expected en %0d data %h", cap_en, cap_data, PB, p1); end
    checks++; if (cap_id !== id1 || cap_id_chg !== 0) begin failures++; $display("FAIL b2b_id1: got %h (changes %0d) expected %h", cap_id, cap_id_chg, id1); end
    capture(PB);
    checks++; if (cap_en !== PB || cap_data !== p2) begin failures++; $display("FAIL b2b_frame2: en %0d data %h expected en %0d data %h", cap_en, cap_data, PB, p2); end
    checks++; if (cap_id !== id1 + 1'b1 || cap_id_chg !== 0) begin failures++; $display("FAIL b2b_id2: got %h (changes %0d) expected %h", cap_id, cap_id_chg, id1 + 1'b1); end
    checks++; if (cap_se_cnt !== 0) begin failures++; $display("FAIL b2b_seq_err: got %0d expected 0", cap_se_cnt); end
    checks++; if (ff_en !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL b2b_idle: en %b empty %b expected 0 1", ff_en, empty); end
  endtask

  task automatic test_overrun();
    logic [PB-1:0] p1, p2, p3;
    p1 = rand_payload(); p2 = rand_payload(); p3 = rand_payload();
    do_reset();
    start = 1'b1;
    send(24'd1, p1);
    step(4);
    sched(100, 24'd2, p2);
    sched(200, 24'd3, p3);
    capture(PB);
    checks++; if (cap_data !== p1) begin failures++; $display("FAIL ovr_frame1: got %h expected %h", cap_data, p1); end
    capture(PB);
    checks++; if (cap_id !== 24'd3 || cap_data !== p3 || cap_en !== PB) begin failures++; $display("FAIL ovr_frame3: id %h en %0d data %h expected id 000003 en %0d data %h", cap_id, cap_en, cap_data, PB, p3); end
    checks++; if (ov_total !== 1) begin failures++; $display("FAIL ovr_pulses: got %0d expected 1", ov_total); end
    checks++; if (int'(cap_se_first) !== CHK || cap_se_cnt !== CHK) begin failures++; $display("FAIL ovr_seq_err: first %b count %0d expected %0d", cap_se_first, cap_se_cnt, CHK); end
    checks++; if (ff_en !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL ovr_idle: en %b empty %b expected 0 1", ff_en, empty); end
  endtask

  task automatic test_nf_reload();
    logic [PB-1:0] p1, p2, p3;
    p1 = rand_payload(); p2 = rand_payload(); p3 = rand_payload();
    do_reset();
    start = 1'b1;
    send(24'd1, p1);
    step(4);
    sched(100, 24'd2, p2);
    sched(PB - 3, 24'd3, p3);
    capture(PB);
    checks++; if (cap_data !== p1) begin failures++; $display("FAIL coinc_frame1: got %h expected %h", cap_data, p1); end
    capture(PB);
    checks++; if (cap_id !== 24'd2 || cap_data !== p2 || cap_en !== PB) begin failures++; $display("FAIL coinc_frame2: id %h en %0d data %h expected id 000002 en %0d data %h", cap_id, cap_en, cap_data, PB, p2); end
    checks++; if (cap_empty_hi !== 0) begin failures++; $display("FAIL coinc_pending: empty high cycles got %0d expected 0", cap_empty_hi); end
    capture(PB);
    checks++; if (cap_id !== 24'd3 || cap_data !== p3 || cap_en !== PB) begin failures++; $display("FAIL coinc_frame3: id %h en %0d data %h expected id 000003 en %0d data %h", cap_id, cap_en, cap_data, PB, p3); end
    checks++; if (ov_total !== 0) begin failures++; $display("FAIL coinc_overrun: got %0d expected 0", ov_total); end
    checks++; if (cap_se_cnt !== 0) begin failures++; $display("FAIL coinc_seq_err: got %0d expected 0", cap_se_cnt); end
  endtask

  task automatic test_start_abort();
    logic [PB-1:0] p1, p2;
    p1 = rand_payload(); p2 = rand_payload();
    do_reset();
    start = 1'b1;
    send(24'd1, p1);
    step(4);
    sched(10, 24'd2, p2);
    capture(100);
    checks++; if (cap_en !== 100 || cap_data[99:0] !== p1[99:0]) begin failures++; $display("FAIL abort_prefix: en %0d data %h expected en 100 data %h", cap_en, cap_data[99:0], p1[99:0]); end
    start = 1'b0;
    step(1);
    checks++; if (ff_en !== 1'b0 || ff_data !== 1'b0) begin failures++; $display("FAIL abort_stop: en %b data %b expected 0 0", ff_en, ff_data); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL abort_kept: empty got %b expected 0", empty); end
    capture(5);
    checks++; if (cap_en !== 0) begin failures++; $display("FAIL abort_idle: en cycles got %0d expected 0", cap_en); end
    start = 1'b1;
    step(1);
    capture(PB);
    checks++; if (cap_id !== 24'd2 || cap_data !== p2 || cap_en !== PB) begin failures++; $display("FAIL abort_resume: id %h en %0d data %h expected id 000002 en %0d data %h", cap_id, cap_en, cap_data, PB, p2); end
  endtask

  task automatic test_reset_mid();
    logic [PB-1:0] p1, p2, p3;
    logic [IB-1:0] id3;
    p1 = rand_payload(); p2 = rand_payload(); p3 = rand_payload(); id3 = IB'($urandom);
    do_reset();
    start = 1'b1;
    send(24'd1, p1);
    step(4);
    sched(50, 24'd2, p2);
    capture(300);
    reset = 1'b1;
    step(1);
    checks++; if (ff_en !== 1'b0 || ff_data !== 1'b0 || overrun !== 1'b0 || seq_err !== 1'b0) begin failures++; $display("FAIL rmid_outputs: en %b data %b ovr %b se %b expected 0 0 0 0", ff_en, ff_data, overrun, seq_err); end
    checks++; if (frameid !== '0 || empty !== 1'b1) begin failures++; $display("FAIL rmid_state: frameid %h empty %b expected 0 1", frameid, empty); end
    reset = 1'b0;
    capture(30);
    checks++; if (cap_en !== 0 || cap_empty_hi !== 30) begin failures++; $display("FAIL rmid_quiet: en %0d empty-high %0d expected 0 30", cap_en, cap_empty_hi); end
    send(id3, p3);
    step(4);
    capture(PB);
    checks++; if (cap_id !== id3 || cap_data !== p3 || cap_en !== PB) begin failures++; $display("FAIL rmid_new: id %h en %0d data %h expected id %h en %0d data %h", cap_id, cap_en, cap_data, id3, PB, p3); end
    checks++; if (cap_se_cnt !== 0) begin failures++; $display("FAIL rmid_seq_err: got %0d expected 0", cap_se_cnt); end
  endtask

  task automatic test_id_wrap();
    logic [PB-1:0] p1, p2, p3;
    p1 = rand_payload(); p2 = rand_payload(); p3 = rand_payload();
    do_reset();
    start = 1'b1;
    send(24'hFFFFFF, p1);
    step(4);
    sched(100, 24'h000000, p2);
    capture(PB);
    checks++; if (cap_se_cnt !== 0 || cap_id !== 24'hFFFFFF) begin failures++; $display("FAIL wrap_first: se %0d id %h expected 0 ffffff", cap_se_cnt, cap_id); end
    sched(100, 24'h000005, p3);
    capture(PB);
    checks++; if (cap_se_cnt !== 0 || cap_id !== 24'h000000 || cap_data !== p2) begin failures++; $display("FAIL wrap_zero: se %0d id %h data %h expected 0 000000 %h", cap_se_cnt, cap_id, cap_data, p2); end
    capture(PB);
    checks++; if (int'(cap_se_first) !== CHK || cap_se_cnt !== CHK || cap_id !== 24'h000005) begin failures++; $display("FAIL wrap_jump: first %b count %0d id %h expected %0d %0d 000005", cap_se_first, cap_se_cnt, cap_id, CHK, CHK); end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    frame_toggle = 1'b0;
    frame_buf    = '0;
    ov_total     = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_nf_reload();
    test_start_abort();
    test_reset_mid();
    test_id_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
